// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage
// ----------------------------------------------------------------------------
// Second pipeline stage of the in-order RV32I core. It decodes the instruction
// word latched by fetch and holds the 32x32 integer register file (x0 reads as
// zero). It produces a registered ID/EX bundle and raises a combinational
// load-use stall request.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   INS_I, PC_I            instruction word and its address from fetch
//   INS_VALID              INS_I/PC_I hold a new instruction
//   FLUSH                  jump taken, discard the instruction being decoded
//   WB_EN, WB_RD, WB_DATA  register write-back port
//   HAZARD_O               combinational load-use stall request to fetch
//   VALID_O, PC_O          ID/EX valid bit and PC (RESET_PC in a bubble)
//   RS1_DATA, RS2_DATA     register operands
//   RS1_O, RS2_O, RD_O     register indices, 0 when the format lacks the field
//   IMM_O, FUNCT3_O        sign-extended immediate, funct3 field
//   ALU_OP, USE_IMM        ALU operation code, operand B is the immediate
//   REG_WE                 instruction writes a non-zero RD_O
//   IS_*                   instruction class flags
//   ILLEGAL_O              unsupported opcode / funct7 combination
// ============================================================================
module decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] INS_I,
    input  logic [31:0] PC_I,
    input  logic        INS_VALID,
    input  logic        FLUSH,
    input  logic        WB_EN,
    input  logic [4:0]  WB_RD,
    input  logic [31:0] WB_DATA,
    output logic        HAZARD_O,
    output logic        VALID_O,
    output logic [31:0] PC_O,
    output logic [31:0] RS1_DATA,
    output logic [31:0] RS2_DATA,
    output logic [4:0]  RS1_O,
    output logic [4:0]  RS2_O,
    output logic [4:0]  RD_O,
    output logic [31:0] IMM_O,
    output logic [2:0]  FUNCT3_O,
    output logic [3:0]  ALU_OP,
    output logic        USE_IMM,
    output logic        REG_WE,
    output logic        IS_LOAD,
    output logic        IS_STORE,
    output logic        IS_BRANCH,
    output logic        IS_JAL,
    output logic        IS_JALR,
    output logic        IS_LUI,
    output logic        IS_AUIPC,
    output logic        ILLEGAL_O
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rs1Field;
    logic [4:0]  w_rs2Field;
    logic [4:0]  w_rdField;

    assign w_opcode   = INS_I[6:0];
    assign w_funct3   = INS_I[14:12];
    assign w_funct7   = INS_I[31:25];
    assign w_rs1Field = INS_I[19:15];
    assign w_rs2Field = INS_I[24:20];
    assign w_rdField  = INS_I[11:7];

    // Decoder outputs
    logic        w_useRs1;
    logic        w_useRs2;
    logic        w_useRd;
    logic [2:0]  w_immSel;
    logic [3:0]  w_aluOp;
    logic [3:0]  w_aluArith;
    logic        w_useImm;
    logic        w_isLoad;
    logic        w_isStore;
    logic        w_isBranch;
    logic        w_isJal;
    logic        w_isJalr;
    logic        w_isLui;
    logic        w_isAuipc;
    logic        w_illegal;
    logic        w_opFunct7Bad;
    logic        w_shiftFunct7Bad;
    logic [31:0] w_imm;
    logic [4:0]  w_rs1Idx;
    logic [4:0]  w_rs2Idx;
    logic [4:0]  w_rdIdx;
    logic        w_regWe;

    // Register file
    logic [31:0] r_regs [32];
    logic [31:0] w_rs1Read;
    logic [31:0] w_rs2Read;
    logic [31:0] w_rs1Data;
    logic [31:0] w_rs2Data;

    logic        w_hazard;
    logic        w_load;

    // ID/EX register
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1Data;
    logic [31:0] r_rs2Data;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_imm;
    logic [2:0]  r_funct3;
    logic [3:0]  r_aluOp;
    logic        r_useImm;
    logic        r_regWe;
    logic        r_isLoad;
    logic        r_isStore;
    logic        r_isBranch;
    logic        r_isJal;
    logic        r_isJalr;
    logic        r_isLui;
    logic        r_isAuipc;
    logic        r_illegal;

    // Only ADD/SUB and SRL/SRA may carry funct7=0x20 in OP; shifts in OP-IMM
    // put funct7 in imm[11:5], so SLLI needs 0 and SRLI/SRAI need 0 or 0x20.
    assign w_opFunct7Bad = !((w_funct7 == 7'h00) ||
                             ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
    assign w_shiftFunct7Bad = ((w_funct3 == 3'b001) && (w_funct7 != 7'h00)) ||
                              ((w_funct3 == 3'b101) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20));

    // funct3 -> ALU op for OP/OP-IMM; SUB exists only in the register form
    always_comb begin
        w_aluArith = ALU_ADD;
        case (w_funct3)
            3'b000:  w_aluArith = ((w_opcode == OPC_OP) && w_funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  w_aluArith = ALU_SLL;
            3'b010:  w_aluArith = ALU_SLT;
            3'b011:  w_aluArith = ALU_SLTU;
            3'b100:  w_aluArith = ALU_XOR;
            3'b101:  w_aluArith = w_funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  w_aluArith = ALU_OR;
            default: w_aluArith = ALU_AND;
        endcase
    end

    // Main decoder. Illegal encodings keep every use/flag at 0 so they
    // neither write, touch memory nor take part in hazard detection.
    always_comb begin
        w_useRs1   = 1'b0;
        w_useRs2   = 1'b0;
        w_useRd    = 1'b0;
        w_immSel   = IMM_NONE;
        w_aluOp    = ALU_ADD;
        w_useImm   = 1'b0;
        w_isLoad   = 1'b0;
        w_isStore  = 1'b0;
        w_isBranch = 1'b0;
        w_isJal    = 1'b0;
        w_isJalr   = 1'b0;
        w_isLui    = 1'b0;
        w_isAuipc  = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                w_useRd  = 1'b1;
                w_immSel = IMM_U;
                w_aluOp  = ALU_PASS_B;
                w_useImm = 1'b1;
                w_isLui  = 1'b1;
            end
            OPC_AUIPC: begin
                w_useRd   = 1'b1;
                w_immSel  = IMM_U;
                w_useImm  = 1'b1;
                w_isAuipc = 1'b1;
            end
            OPC_JAL: begin
                w_useRd  = 1'b1;
                w_immSel = IMM_J;
                w_useImm = 1'b1;
                w_isJal  = 1'b1;
            end
            OPC_JALR: begin
                w_useRs1 = 1'b1;
                w_useRd  = 1'b1;
                w_immSel = IMM_I;
                w_useImm = 1'b1;
                w_isJalr = 1'b1;
            end
            OPC_BRANCH: begin
                w_useRs1   = 1'b1;
                w_useRs2   = 1'b1;
                w_immSel   = IMM_B;
                w_aluOp    = ALU_SUB;
                w_isBranch = 1'b1;
            end
            OPC_LOAD: begin
                w_useRs1 = 1'b1;
                w_useRd  = 1'b1;
                w_immSel = IMM_I;
                w_useImm = 1'b1;
                w_isLoad = 1'b1;
            end
            OPC_STORE: begin
                w_useRs1  = 1'b1;
                w_useRs2  = 1'b1;
                w_immSel  = IMM_S;
                w_useImm  = 1'b1;
                w_isStore = 1'b1;
            end
            OPC_OPIMM: begin
                if (w_shiftFunct7Bad) begin
                    w_illegal = 1'b1;
                end else begin
                    w_useRs1 = 1'b1;
                    w_useRd  = 1'b1;
                    w_immSel = IMM_I;
                    w_aluOp  = w_aluArith;
                    w_useImm = 1'b1;
                end
            end
            OPC_OP: begin
                if (w_opFunct7Bad) begin
                    w_illegal = 1'b1;
                end else begin
                    w_useRs1 = 1'b1;
                    w_useRs2 = 1'b1;
                    w_useRd  = 1'b1;
                    w_aluOp  = w_aluArith;
                end
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Executed as a NOP: valid, but no register or memory effect
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_imm = 32'h0;
        case (w_immSel)
            IMM_I:   w_imm = {{20{INS_I[31]}}, INS_I[31:20]};
            IMM_S:   w_imm = {{20{INS_I[31]}}, INS_I[31:25], INS_I[11:7]};
            IMM_B:   w_imm = {{19{INS_I[31]}}, INS_I[31], INS_I[7], INS_I[30:25], INS_I[11:8], 1'b0};
            IMM_U:   w_imm = {INS_I[31:12], 12'h000};
            IMM_J:   w_imm = {{11{INS_I[31]}}, INS_I[31], INS_I[19:12], INS_I[20], INS_I[30:21], 1'b0};
            default: w_imm = 32'h0;
        endcase
    end

    assign w_rs1Idx = w_useRs1 ? w_rs1Field : 5'd0;
    assign w_rs2Idx = w_useRs2 ? w_rs2Field : 5'd0;
    assign w_rdIdx  = w_useRd  ? w_rdField  : 5'd0;
    assign w_regWe  = w_useRd && (w_rdField != 5'd0);

    // Register file storage; x0 is never written so it stays zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else if (WB_EN && (WB_RD != 5'd0)) begin
            r_regs[WB_RD] <= WB_DATA;
        end
    end

    // Reads with write-through bypass so a same-cycle write-back is seen
    always_comb begin
        if (w_rs1Field == 5'd0) begin
            w_rs1Read = 32'h0;
        end else if (WB_EN && (WB_RD == w_rs1Field)) begin
            w_rs1Read = WB_DATA;
        end else begin
            w_rs1Read = r_regs[w_rs1Field];
        end
        if (w_rs2Field == 5'd0) begin
            w_rs2Read = 32'h0;
        end else if (WB_EN && (WB_RD == w_rs2Field)) begin
            w_rs2Read = WB_DATA;
        end else begin
            w_rs2Read = r_regs[w_rs2Field];
        end
    end

    assign w_rs1Data = w_useRs1 ? w_rs1Read : 32'h0;
    assign w_rs2Data = w_useRs2 ? w_rs2Read : 32'h0;

    // Unused source fields are forced to 0, and r_rd is required non-zero,
    // so only real operand reads can match the load destination.
    assign w_hazard = r_valid && r_isLoad && (r_rd != 5'd0) && INS_VALID &&
                      ((w_rs1Idx == r_rd) || (w_rs2Idx == r_rd));
    assign HAZARD_O = w_hazard;

    assign w_load = !FLUSH && !w_hazard && INS_VALID;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !w_load) begin
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_rs1Data  <= 32'h0;
            r_rs2Data  <= 32'h0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_imm      <= 32'h0;
            r_funct3   <= 3'd0;
            r_aluOp    <= ALU_ADD;
            r_useImm   <= 1'b0;
            r_regWe    <= 1'b0;
            r_isLoad   <= 1'b0;
            r_isStore  <= 1'b0;
            r_isBranch <= 1'b0;
            r_isJal    <= 1'b0;
            r_isJalr   <= 1'b0;
            r_isLui    <= 1'b0;
            r_isAuipc  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= PC_I;
            r_rs1Data  <= w_rs1Data;
            r_rs2Data  <= w_rs2Data;
            r_rs1      <= w_rs1Idx;
            r_rs2      <= w_rs2Idx;
            r_rd       <= w_rdIdx;
            r_imm      <= w_imm;
            r_funct3   <= w_funct3;
            r_aluOp    <= w_aluOp;
            r_useImm   <= w_useImm;
            r_regWe    <= w_regWe;
            r_isLoad   <= w_isLoad;
            r_isStore  <= w_isStore;
            r_isBranch <= w_isBranch;
            r_isJal    <= w_isJal;
            r_isJalr   <= w_isJalr;
            r_isLui    <= w_isLui;
            r_isAuipc  <= w_isAuipc;
            r_illegal  <= w_illegal;
        end
    end

    assign VALID_O   = r_valid;
    assign PC_O      = r_pc;
    assign RS1_DATA  = r_rs1Data;
    assign RS2_DATA  = r_rs2Data;
    assign RS1_O     = r_rs1;
    assign RS2_O     = r_rs2;
    assign RD_O      = r_rd;
    assign IMM_O     = r_imm;
    assign FUNCT3_O  = r_funct3;
    assign ALU_OP    = r_aluOp;
    assign USE_IMM   = r_useImm;
    assign REG_WE    = r_regWe;
    assign IS_LOAD   = r_isLoad;
    assign IS_STORE  = r_isStore;
    assign IS_BRANCH = r_isBranch;
    assign IS_JAL    = r_isJal;
    assign IS_JALR   = r_isJalr;
    assign IS_LUI    = r_isLui;
    assign IS_AUIPC  = r_isAuipc;
    assign ILLEGAL_O = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage
// ----------------------------------------------------------------------------
// Directed testbench for decode_stage. A reference model of the ID/EX bundle
// and register file, built from the RV32I instruction formats, is compared
// with the DUT on every falling edge; directed checks pin key literal values.
// ============================================================================
module tb_decode_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        insValid = 1'b0;
    logic        flush = 1'b0;
    logic        wbEn = 1'b0;
    logic [4:0]  wbRd = 5'd0;
    logic [31:0] wbData = 32'h0;

    logic        hazardO, validO, useImm, regWe, illegalO;
    logic        isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc;
    logic [31:0] pcO, rs1Data, rs2Data, immO;
    logic [4:0]  rs1O, rs2O, rdO;
    logic [2:0]  funct3O;
    logic [3:0]  aluOp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .INS_I(ins), .PC_I(pc), .INS_VALID(insValid),
        .FLUSH(flush), .WB_EN(wbEn), .WB_RD(wbRd), .WB_DATA(wbData),
        .HAZARD_O(hazardO), .VALID_O(validO), .PC_O(pcO),
        .RS1_DATA(rs1Data), .RS2_DATA(rs2Data), .RS1_O(rs1O), .RS2_O(rs2O),
        .RD_O(rdO), .IMM_O(immO), .FUNCT3_O(funct3O), .ALU_OP(aluOp),
        .USE_IMM(useImm), .REG_WE(regWe), .IS_LOAD(isLoad), .IS_STORE(isStore),
        .IS_BRANCH(isBranch), .IS_JAL(isJal), .IS_JALR(isJalr), .IS_LUI(isLui),
        .IS_AUIPC(isAuipc), .ILLEGAL_O(illegalO)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1Data;
        logic [31:0] rs2Data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        useImm;
        logic        regWe;
        logic        isLoad;
        logic        isStore;
        logic        isBranch;
        logic        isJal;
        logic        isJalr;
        logic        isLui;
        logic        isAuipc;
        logic        illegal;
    } bundle_t;

    logic [31:0] mregs [32];
    bundle_t     expB;

    function automatic bundle_t bubble();
        bundle_t b = '0;
        b.pc = RST_PC;
        return b;
    endfunction

    function automatic logic [31:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wbEn && wbRd == idx) return wbData;
        return mregs[idx];
    endfunction

    // Format letter: R I S B U J, N for a NOP, X for illegal
    function automatic bundle_t decodeModel(input logic [31:0] w, input logic [31:0] p);
        bundle_t b = '0;
        byte fmt;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [3:0] arith [8];
        f7 = w[31:25];
        f3 = w[14:12];
        arith[0] = 4'd0; arith[1] = 4'd2; arith[2] = 4'd3; arith[3] = 4'd4;
        arith[4] = 4'd5; arith[5] = f7[5] ? 4'd7 : 4'd6; arith[6] = 4'd8; arith[7] = 4'd9;
        b.valid = 1'b1;
        b.pc = p;
        b.f3 = f3;
        fmt = "X";
        case (w[6:0])
            7'h37: begin fmt = "U"; b.isLui = 1; b.alu = 4'd10; b.useImm = 1; end
            7'h17: begin fmt = "U"; b.isAuipc = 1; b.useImm = 1; end
            7'h6F: begin fmt = "J"; b.isJal = 1; b.useImm = 1; end
            7'h67: begin fmt = "I"; b.isJalr = 1; b.useImm = 1; end
            7'h63: begin fmt = "B"; b.isBranch = 1; b.alu = 4'd1; end
            7'h03: begin fmt = "I"; b.isLoad = 1; b.useImm = 1; end
            7'h23: begin fmt = "S"; b.isStore = 1; b.useImm = 1; end
            7'h13: begin
                if ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 7'h20)) fmt = "X";
                else begin fmt = "I"; b.alu = arith[f3]; b.useImm = 1; end
            end
            7'h33: begin
                if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                    fmt = "R";
                    b.alu = (f3 == 0 && f7[5]) ? 4'd1 : arith[f3];
                end else fmt = "X";
            end
            7'h0F, 7'h73: fmt = "N";
            default: fmt = "X";
        endcase
        b.illegal = (fmt == "X");
        if (fmt inside {"R", "I", "S", "B"}) begin
            b.rs1 = w[19:15];
            b.rs1Data = modelRead(w[19:15]);
        end
        if (fmt inside {"R", "S", "B"}) begin
            b.rs2 = w[24:20];
            b.rs2Data = modelRead(w[24:20]);
        end
        if (fmt inside {"R", "I", "U", "J"}) begin
            b.rd = w[11:7];
            b.regWe = (w[11:7] != 0);
        end
        case (fmt)
            "I": b.imm = 32'($signed(w[31:20]));
            "S": b.imm = 32'($signed({w[31:25], w[11:7]}));
            "B": b.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            "U": b.imm = {w[31:12], 12'h0};
            "J": b.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
            default: b.imm = 32'h0;
        endcase
        return b;
    endfunction

    function automatic logic modelHazard();
        bundle_t nb;
        nb = decodeModel(ins, pc);
        return expB.valid && expB.isLoad && expB.rd != 0 && insValid &&
               ((nb.rs1 == expB.rd) || (nb.rs2 == expB.rd));
    endfunction

    // Reference model: register file plus ID/EX bundle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] <= 32'h0;
            expB <= bubble();
        end else begin
            expB <= (flush || modelHazard() || !insValid) ? bubble() : decodeModel(ins, pc);
            if (wbEn && wbRd != 0) mregs[wbRd] <= wbData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        checkOutput("m.HAZARD_O", 32'(hazardO), 32'(modelHazard()));
        checkOutput("m.VALID_O", 32'(validO), 32'(expB.valid));
        checkOutput("m.PC_O", pcO, expB.pc);
        checkOutput("m.RS1_DATA", rs1Data, expB.rs1Data);
        checkOutput("m.RS2_DATA", rs2Data, expB.rs2Data);
        checkOutput("m.RS1_O", 32'(rs1O), 32'(expB.rs1));
        checkOutput("m.RS2_O", 32'(rs2O), 32'(expB.rs2));
        checkOutput("m.RD_O", 32'(rdO), 32'(expB.rd));
        checkOutput("m.IMM_O", immO, expB.imm);
        checkOutput("m.FUNCT3_O", 32'(funct3O), 32'(expB.f3));
        checkOutput("m.ALU_OP", 32'(aluOp), 32'(expB.alu));
        checkOutput("m.flags", {22'h0, useImm, regWe, isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc, illegalO},
                    {22'h0, expB.useImm, expB.regWe, expB.isLoad, expB.isStore, expB.isBranch,
                     expB.isJal, expB.isJalr, expB.isLui, expB.isAuipc, expB.illegal});
    end

    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] p, input logic v, input logic f,
                                 input logic we, input logic [4:0] rd, input logic [31:0] d);
        ins = w; pc = p; insValid = v; flush = f; wbEn = we; wbRd = rd; wbData = d;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] vecs [14];

    initial begin
        vecs = '{32'h40628433, 32'h00532223, 32'hFE5288E3, 32'h123452B7, 32'h00001097,
                 32'h008000EF, 32'h000080E7, 32'h0000000F, 32'h00000073, 32'h02000033,
                 32'h40001013, 32'h0042D293, 32'hFFF2C293, 32'h0062A2B3};
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        checkOutput("reset VALID_O", 32'(validO), 32'h0);
        checkOutput("reset PC_O", pcO, RST_PC);
        checkOutput("reset HAZARD_O", 32'(hazardO), 32'h0);

        // ADDI x1,x0,5
        applyStimulus(32'h00500093, 32'h100, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("addi VALID_O", 32'(validO), 32'h1);
        checkOutput("addi RD_O", 32'(rdO), 32'h1);
        checkOutput("addi RS1_O", 32'(rs1O), 32'h0);
        checkOutput("addi IMM_O", immO, 32'h5);
        checkOutput("addi ALU_OP", 32'(aluOp), 32'h0);
        checkOutput("addi USE_IMM", 32'(useImm), 32'h1);
        checkOutput("addi REG_WE", 32'(regWe), 32'h1);
        checkOutput("addi RS1_DATA", rs1Data, 32'h0);
        checkOutput("addi PC_O", pcO, 32'h100);

        // ADD x6,x5,x0 with same-cycle write-back of x5
        applyStimulus(32'h00028333, 32'h104, 1, 0, 1, 5, 32'hDEADBEEF);
        cycle();
        checkOutput("bypass RS1_DATA", rs1Data, 32'hDEADBEEF);
        checkOutput("bypass ALU_OP", 32'(aluOp), 32'h0);
        checkOutput("bypass RD_O", 32'(rdO), 32'h6);
        applyStimulus(32'h00000333, 32'h108, 1, 0, 1, 0, 32'hCAFEF00D);
        cycle();
        checkOutput("x0 RS1_DATA", rs1Data, 32'h0);
        checkOutput("x0 RS2_DATA", rs2Data, 32'h0);
        applyStimulus(32'h00028333, 32'h10C, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("x5 stored", rs1Data, 32'hDEADBEEF);

        // Load-use: LW x2,0(x1) then ADD x3,x2,x2
        applyStimulus(32'h0000A103, 32'h110, 1, 0, 0, 0, 0);
        cycle();
        applyStimulus(32'h002101B3, 32'h114, 1, 0, 0, 0, 0);
        checkOutput("hazard raised", 32'(hazardO), 32'h1);
        cycle();
        checkOutput("hazard bubble VALID_O", 32'(validO), 32'h0);
        checkOutput("hazard dropped", 32'(hazardO), 32'h0);
        cycle();
        checkOutput("held ADD VALID_O", 32'(validO), 32'h1);
        checkOutput("held ADD RD_O", 32'(rdO), 32'h3);
        checkOutput("held ADD PC_O", pcO, 32'h114);

        // Flush of a valid instruction
        applyStimulus(32'h00500093, 32'h200, 1, 1, 0, 0, 0);
        cycle();
        checkOutput("flush VALID_O", 32'(validO), 32'h0);
        checkOutput("flush REG_WE", 32'(regWe), 32'h0);
        checkOutput("flush PC_O", pcO, RST_PC);

        // Flush coincident with a load-use hazard
        applyStimulus(32'h0000A103, 32'h204, 1, 0, 0, 0, 0);
        cycle();
        applyStimulus(32'h002101B3, 32'h208, 1, 1, 0, 0, 0);
        checkOutput("flush+hazard HAZARD_O", 32'(hazardO), 32'h1);
        cycle();
        applyStimulus(32'h002101B3, 32'h208, 1, 0, 0, 0, 0);
        checkOutput("flush+hazard VALID_O", 32'(validO), 32'h0);
        checkOutput("flush+hazard next HAZARD_O", 32'(hazardO), 32'h0);
        cycle();

        // Illegal and SRAI x0
        applyStimulus(32'hFFFFFFFF, 32'h300, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("illegal ILLEGAL_O", 32'(illegalO), 32'h1);
        checkOutput("illegal VALID_O", 32'(validO), 32'h1);
        checkOutput("illegal REG_WE", 32'(regWe), 32'h0);
        checkOutput("illegal LOAD/STORE", {30'h0, isLoad, isStore}, 32'h0);
        applyStimulus(32'h40005013, 32'h304, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("srai ILLEGAL_O", 32'(illegalO), 32'h0);
        checkOutput("srai ALU_OP", 32'(aluOp), 32'h7);
        checkOutput("srai REG_WE", 32'(regWe), 32'h0);

        // Model-checked mix of formats with varied write-backs
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], 32'h400 + 32'(i * 4), (i % 5) != 4, 0, (i % 2) == 0,
                          5'(i + 2), 32'h1000_0000 + 32'(i * 32'h0101_0101));
            cycle();
        end
        applyStimulus(32'h123452B7, 32'h500, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("lui IMM_O", immO, 32'h12345000);
        checkOutput("lui ALU_OP", 32'(aluOp), 32'd10);

        // Write x7, read it back, then reset mid-stream
        applyStimulus(32'h00000013, 32'h600, 1, 0, 1, 7, 32'h12345678);
        cycle();
        applyStimulus(32'h00038433, 32'h604, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("x7 written", rs1Data, 32'h12345678);
        insValid = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async reset VALID_O", 32'(validO), 32'h0);
        checkOutput("async reset PC_O", pcO, RST_PC);
        checkOutput("async reset RD_O", 32'(rdO), 32'h0);
        cycle();
        rst = 1'b0;
        applyStimulus(32'h00038433, 32'h700, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("x7 cleared", rs1Data, 32'h0);
        checkOutput("post-reset VALID_O", 32'(validO), 32'h1);
        applyStimulus(32'h0, 32'h0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Second pipeline stage of the in-order RV32I core. It consumes the instruction word and PC latched by the fetch stage and decodes the instruction. It holds the 32x32 integer register file (x0 hardwired to zero) with a write-back port. It produces a registered ID/EX bundle: operands, immediate, control fields and a valid bit. It also detects load-use hazards and drops its output to a bubble on a jump flush.

## Interface
Parameters:
- RESET_PC, 32'h0, value driven on PC_O while reset/bubble.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset; rst, asynchronous, active-high.
- INS_I  in  32  instruction word from fetch.
- PC_I  in  32  address of INS_I.
- INS_VALID  in  1  INS_I/PC_I hold a new instruction; driven as !stall_ff of fetch.
- FLUSH  in  1  jump taken (jmp_s); discard the instruction being decoded.
- WB_EN  in  1  register write-back enable.
- WB_RD  in  5  write-back destination.
- WB_DATA  in  32  write-back value.
- HAZARD_O  out  1  combinational load-use stall request, OR'd into the fetch stall.
- VALID_O  out  1  ID/EX bundle holds a real instruction.
- PC_O  out  32  PC of decoded instruction.
- RS1_DATA, RS2_DATA  out  32  each  register operands.
- RS1_O, RS2_O, RD_O  out  5  each  register indices; forced to 0 when the format does not use the field.
- IMM_O  out  32  sign-extended immediate for the I/S/B/U/J format.
- FUNCT3_O  out  3  funct3 field.
- ALU_OP  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- USE_IMM  out  1  ALU operand B is IMM_O.
- REG_WE  out  1  instruction writes RD_O (0 when RD=x0).
- IS_LOAD, IS_STORE, IS_BRANCH, IS_JAL, IS_JALR, IS_LUI, IS_AUIPC  out  1 each  class flags.
- ILLEGAL_O  out  1  unsupported opcode/funct combination.

## Operation
- Register file: 32 entries x 32 bits.
  - Written at posedge when WB_EN && WB_RD!=0.
  - Reads are combinational on INS_I[19:15]/[24:20].
  - Write-through bypass: a same-cycle read of WB_RD (when it is non-zero) returns WB_DATA.
  - Reads of x0 always return 0.
- Decode is combinational from INS_I into the ID/EX register.
  - Opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - FENCE/SYSTEM decode as a NOP with VALID_O=1 and REG_WE=0.
  - Any other opcode, or a bad funct7 in OP or in shifts, sets ILLEGAL_O=1 with all write/memory flags 0.
- ALU_OP mapping:
  - LOAD, STORE, JALR, AUIPC: ADD.
  - BRANCH: SUB.
  - LUI: PASS_B.
  - OP/OP-IMM: from funct3 and funct7[5]. SUB only for OP; SRA/SRAI from funct7[5].
- Load-use hazard, all of the following true:
  - VALID_O && IS_LOAD && RD_O!=0 (the instruction currently in ID/EX),
  - INS_VALID,
  - the incoming instruction reads RD_O as rs1 or rs2 (RS1/RS2 as used by its format).
  - Then HAZARD_O=1 and the next ID/EX is a bubble. Fetch holds INS_I/PC_I, and decode re-evaluates the same instruction on the next cycle.
- Capture priority at each posedge:
  1. FLUSH: bubble.
  2. Hazard: bubble.
  3. INS_VALID: load decoded bundle.
  4. Otherwise: bubble.
- A bubble sets VALID_O=0, every class flag, REG_WE and ILLEGAL_O to 0, and PC_O=RESET_PC. The data fields are don't-care, but the implementation zeroes them.

## Timing
- Latency: 1 cycle. INS_I sampled at edge N appears on the outputs after edge N; throughput is 1 instruction/cycle.
- Reset (asynchronous):
  - All ID/EX outputs 0, with PC_O=RESET_PC.
  - All register file entries 0.
  - HAZARD_O is 0 during reset because VALID_O is 0.
- WB_EN together with a read of the same register in the same cycle: the bypass value is captured into RS*_DATA at that edge.
- FLUSH coincident with a hazard: FLUSH wins. The next cycle has VALID_O=0, so HAZARD_O drops.
- WB_EN to x0: ignored, and x0 stays 0.
- The ID/EX register does not hold. There is no downstream stall input, and the execute stage always consumes.
- HAZARD_O lasts exactly 1 cycle per load-use pair, because the bubble clears IS_LOAD.

## Test plan
- Reset, then INS_I=0x00500093 (ADDI x1,x0,5) with INS_VALID=1 -> next cycle:
  - VALID_O=1, RD_O=1, RS1_O=0, IMM_O=5,
  - ALU_OP=0, USE_IMM=1, REG_WE=1, RS1_DATA=0.
- WB_EN=1, WB_RD=5, WB_DATA=0xDEADBEEF in the same cycle as INS_I=0x00028333 (ADD x6,x5,x0) -> RS1_DATA=0xDEADBEEF, ALU_OP=0, RD_O=6. Also, WB_RD=0 followed by a read of x0 -> 0.
- 0x0000A103 (LW x2,0(x1)) then 0x002101B3 (ADD x3,x2,x2), fetch honouring HAZARD_O ->
  - HAZARD_O=1 for one cycle, followed by a VALID_O=0 bubble,
  - then the ADD is presented with VALID_O=1.
- Valid instruction with FLUSH=1 -> VALID_O=0, REG_WE=0, PC_O=RESET_PC. FLUSH=1 during a load-use hazard -> bubble, and HAZARD_O=0 the following cycle.
- INS_I=0xFFFFFFFF -> ILLEGAL_O=1, VALID_O=1, REG_WE=0, IS_LOAD=IS_STORE=0. INS_I=0x40005013 (SRAI x0,x0,0) -> ILLEGAL_O=0, ALU_OP=7, REG_WE=0.
- rst asserted mid-stream after writing x7=0x12345678 -> outputs immediately 0 and VALID_O=0. After release, reading x7 returns 0.
